// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Serial receive front end. Synchronises the raw uart_rx pin, oversamples at
//   16x baud and frames 8N1 characters (8E1 when UART_RX_PARITY_EN is defined).
//   Each received byte is held on rx_data with rx_avail set until the consumer
//   strobes rx_ack. Framing (and parity) errors and dropped bytes are reported
//   as one-cycle pulses.
//
// Build option:
//   UART_RX_PARITY_EN  - defined: 8E1 frames with an even-parity check;
//                        undefined: 8N1 frames, no parity logic.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   uart_rx     in   asynchronous serial input, idles high
//   rx_data     out  last received byte
//   rx_avail    out  rx_data valid, held until rx_ack
//   rx_ack      in   consumer strobe, clears rx_avail
//   rx_ferr     out  one-cycle pulse: bad stop bit (or parity)
//   rx_overrun  out  one-cycle pulse: byte dropped, rx_avail still set
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIVISOR  = ((CLK_FREQ / (16 * BAUD)) >= 1) ?
                                    (CLK_FREQ / (16 * BAUD)) : 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_ferr,
  output logic       rx_overrun
);

  localparam int unsigned TCNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned SCNT_W = 4;
  localparam int unsigned BIDX_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(DIVISOR - 1);
  localparam logic [SCNT_W-1:0] SCNT_MID = SCNT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_ACCEPT = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  // Synchroniser and edge detect
  logic [1:0]        r_sync;
  logic [1:0]        r_sync_vld;
  logic              r_rxs_d;
  logic              w_rxs;
  logic              w_fall;

  // FSM and datapath registers
  state_t            r_state;
  state_t            w_state_nxt;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic [SCNT_W-1:0] r_scnt;
  logic [SCNT_W-1:0] w_scnt_nxt;
  logic [BIDX_W-1:0] r_bidx;
  logic [BIDX_W-1:0] w_bidx_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              r_stop;
  logic              w_stop_nxt;
`ifdef UART_RX_PARITY_EN
  logic              r_perr;
  logic              w_perr_nxt;
`endif
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_avail;
  logic              w_avail_nxt;
  logic              r_ferr;
  logic              w_ferr_nxt;
  logic              r_ovr;
  logic              w_ovr_nxt;

  logic              w_tick;
  logic              w_sample;
  logic              w_frame_ok;

  assign w_rxs = r_sync[1];

  // The previous-sample register only follows rxs once the synchroniser holds
  // real pin data, so a line that is low out of reset cannot fake a falling
  // edge from the reset value of the synchroniser.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync     <= 2'b11;
      r_sync_vld <= 2'b00;
      r_rxs_d    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], uart_rx};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_rxs_d    <= r_sync_vld[1] ? w_rxs : 1'b0;
    end
  end

  assign w_fall   = ~w_rxs & r_rxs_d;
  assign w_tick   = (r_tcnt == TCNT_MAX);
  assign w_sample = w_tick && (r_scnt == SCNT_MID);

`ifdef UART_RX_PARITY_EN
  assign w_frame_ok = r_stop & ~r_perr;
`else
  assign w_frame_ok = r_stop;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counters, shift register and output decisions
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_scnt_nxt  = r_scnt;
    w_bidx_nxt  = r_bidx;
    w_shift_nxt = r_shift;
    w_stop_nxt  = r_stop;
`ifdef UART_RX_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    w_data_nxt  = r_data;
    w_avail_nxt = r_avail & ~rx_ack;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;

    // Oversample timebase; the sample counter wraps every 16 ticks so each
    // later mid-bit sample lands one bit time after the previous one.
    if (r_state != S_IDLE) begin
      w_tcnt_nxt = w_tick ? '0 : r_tcnt + TCNT_W'(1);
      if (w_tick) begin
        w_scnt_nxt = r_scnt + SCNT_W'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        w_tcnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
          w_scnt_nxt  = '0;
        end
      end

      S_START: begin
        if (w_sample) begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bidx_nxt  = '0;
          end
        end
      end

      S_DATA: begin
        if (w_sample) begin
          w_shift_nxt = {w_rxs, r_shift[DATA_W-1:1]};
          if (r_bidx == BIDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bidx_nxt = r_bidx + BIDX_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          w_perr_nxt  = w_rxs ^ (^r_shift);
          w_state_nxt = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (w_sample) begin
          w_stop_nxt  = w_rxs;
          w_state_nxt = S_ACCEPT;
        end
      end

      // One cycle after the stop sample: deliver, drop or flag the byte.
      S_ACCEPT: begin
        w_state_nxt = S_IDLE;
        if (w_frame_ok) begin
          if (!r_avail || rx_ack) begin
            w_data_nxt  = r_shift;
            w_avail_nxt = 1'b1;
          end else begin
            w_ovr_nxt = 1'b1;
          end
        end else begin
          w_ferr_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tcnt  <= '0;
      r_scnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_stop  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      r_data  <= '0;
      r_avail <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shift <= w_shift_nxt;
      r_stop  <= w_stop_nxt;
`ifdef UART_RX_PARITY_EN
      r_perr  <= w_perr_nxt;
`endif
      r_data  <= w_data_nxt;
      r_avail <= w_avail_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign rx_data    = r_data;
  assign rx_avail   = r_avail;
  assign rx_ferr    = r_ferr;
  assign rx_overrun = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core at DIVISOR=2 (32 clocks per bit).
//   Expected bytes are queued as frames are driven; a monitor queues every
//   byte the DUT delivers, and the two queues are compared after each step.
//   Build with UART_RX_PARITY_EN to exercise the 8E1 variant.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 340;
`else
  localparam int LAT = 308;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_ack;
  logic       rx_ferr;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int n_ferr_cyc = 0;
  int n_ferr_rise = 0;
  int n_ovr_cyc = 0;
  int n_ovr_rise = 0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr = 1'b0;
  logic       prev_avail = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx_core #(
    .CLK_FREQ(3200000),
    .BAUD    (100000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_ack    (rx_ack),
    .rx_ferr   (rx_ferr),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: counts pulses and captures every delivered byte.
  always @(posedge clk) begin
    #1;
    if (rx_ferr === 1'b1) n_ferr_cyc++;
    if (rx_ferr === 1'b1 && !prev_ferr) n_ferr_rise++;
    if (rx_overrun === 1'b1) n_ovr_cyc++;
    if (rx_overrun === 1'b1 && !prev_ovr) n_ovr_rise++;
    if (rx_avail === 1'b1 && (!prev_avail || rx_data !== prev_data)) begin
      got_q.push_back(rx_data);
      if (!prev_avail) rise_cyc = cyc;
    end
    prev_ferr  = (rx_ferr === 1'b1);
    prev_ovr   = (rx_overrun === 1'b1);
    prev_avail = (rx_avail === 1'b1);
    prev_data  = rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_drain(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  // Drive one frame starting at a negedge; optionally strobe rx_ack so that
  // it is sampled ack_off clocks after the start edge (0 = never).
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic bad_par, input int ack_off);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ bad_par;
    bits[10] = stop_b;
    nb = 11;
`else
    bits[9] = stop_b;
    bits[10] = bad_par;
    nb = 10;
`endif
    start_cyc = cyc;
    for (int k = 0; k < nb * BIT_CLKS; k++) begin
      uart_rx = bits[k / BIT_CLKS];
      rx_ack = (ack_off != 0) && (k == ack_off - 1);
      @(negedge clk);
    end
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    // Reset with the line low
    reset_n = 1'b0;
    uart_rx = 1'b0;
    rx_ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_avail", 32'(rx_avail), 32'(0));
    chk("rst_data", 32'(rx_data), 32'(0));
    chk("rst_ferr", 32'(rx_ferr), 32'(0));
    chk("rst_overrun", 32'(rx_overrun), 32'(0));

    // Line still low after release: no frame may start
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_avail", 32'(rx_avail), 32'(0));
    chk("post_rst_ferr", 32'(n_ferr_rise), 32'(0));
    sb_drain("post_rst");
    idle(40);

    // Good byte, latency and ack
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(16);
    chk("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
    chk("a5_avail", 32'(rx_avail), 32'(1));
    chk("a5_ferr", 32'(n_ferr_rise), 32'(0));
    sb_drain("a5");
    ack_pulse();
    chk("a5_ack_clear", 32'(rx_avail), 32'(0));

    // Start-bit glitch
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    idle(100);
    chk("glitch_avail", 32'(rx_avail), 32'(0));
    chk("glitch_ferr", 32'(n_ferr_rise), 32'(0));
    sb_drain("glitch");

    // Framing error: stop bit low
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    idle(40);
    chk("ferr_pulses", 32'(n_ferr_rise), 32'(1));
    chk("ferr_width", 32'(n_ferr_cyc), 32'(1));
    chk("ferr_avail", 32'(rx_avail), 32'(0));
    sb_drain("ferr");

    // Break: long low gives a single framing error
    uart_rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    idle(40);
    chk("break_pulses", 32'(n_ferr_rise), 32'(2));
    chk("break_width", 32'(n_ferr_cyc), 32'(2));
    chk("break_avail", 32'(rx_avail), 32'(0));
    sb_drain("break");

    // Overrun: two back-to-back bytes, no ack
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    idle(40);
    chk("ovr_pulses", 32'(n_ovr_rise), 32'(1));
    chk("ovr_width", 32'(n_ovr_cyc), 32'(1));
    chk("ovr_data", 32'(rx_data), 32'(8'h11));
    chk("ovr_avail", 32'(rx_avail), 32'(1));
    sb_drain("ovr");
    ack_pulse();
    chk("ovr_ack_clear", 32'(rx_avail), 32'(0));

    // Ack coincident with the second accept: new byte replaces old one
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, LAT);
    idle(40);
    chk("ackacc_no_ovr", 32'(n_ovr_rise), 32'(1));
    chk("ackacc_data", 32'(rx_data), 32'(8'h22));
    chk("ackacc_avail", 32'(rx_avail), 32'(1));
    sb_drain("ackacc");
    ack_pulse();

    // Reset in the middle of a frame while a byte is held
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    idle(16);
    sb_drain("pre_midrst");
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    chk("midrst_avail", 32'(rx_avail), 32'(0));
    chk("midrst_data", 32'(rx_data), 32'(0));
    reset_n = 1'b1;
    idle(40);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0, 0);
    idle(16);
    chk("midrst_ferr", 32'(n_ferr_rise), 32'(2));
    sb_drain("post_midrst");
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(16);
    chk("par_ok_ferr", 32'(n_ferr_rise), 32'(2));
    sb_drain("par_ok");
    ack_pulse();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(40);
    chk("par_bad_ferr", 32'(n_ferr_rise), 32'(3));
    chk("par_bad_avail", 32'(rx_avail), 32'(0));
    sb_drain("par_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
